reg_file: RTL and testbench

//  MIPS GPR file: 32 x 32-bit registers, two combinational read ports for the decode stage, one write port.
//  The write port is driven by the write-back stage: reg_write_enable, bypass_reg_addr_wb and the wb data.

---
 rtl/reg_file_pkg.sv | 24 ++
 rtl/reg_file_if.sv | 49 ++++
 rtl/reg_file_read_port.sv | 57 +++++
 rtl/reg_file.sv | 87 ++++++++
 tb/tb_reg_file.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared constants and helpers for the MIPS GPR file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_file_pkg;

    localparam int          c_DATA_W   = 32;
    localparam int          c_ADDR_W   = 5;
    localparam int          c_CNT_W    = 32;
    localparam logic [4:0]  c_REG_ZERO = 5'd0;

    // Write-back request as seen at the consuming end of the interface.
    typedef struct packed {
        logic                  we;
        logic [c_ADDR_W-1:0]   waddr;
        logic [c_DATA_W-1:0]   wdata;
    } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/reg_file_if.sv
// ============================================================================
// Module      : reg_file_if
// Description : Write-back and decode read bus of the GPR file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W,
    parameter int CNT_W  = c_CNT_W
);

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic [CNT_W-1:0]  wr_cnt;

    modport master (
        output we,
        output waddr,
        output wdata,
        output raddr1,
        output raddr2,
        input  rdata1,
        input  rdata2,
        input  wr_cnt
    );

    modport slave (
        input  we,
        input  waddr,
        input  wdata,
        input  raddr1,
        input  raddr2,
        output rdata1,
        output rdata2,
        output wr_cnt
    );

endinterface

`default_nettype wire

// File: rtl/reg_file_read_port.sv
// ============================================================================
// Module      : reg_file_read_port
// Description : One combinational GPR read port: index mux, $0 override and
//               optional write-first bypass (REG_FILE_WRITE_BYPASS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
)(
    input  wire logic              rd_en,
    input  wire logic [ADDR_W-1:0] raddr,
    input  wire logic [DATA_W-1:0] regs [2**ADDR_W],
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [DATA_W-1:0] wdata,
    output logic      [DATA_W-1:0] rdata
);

    logic              w_is_zero;
    logic              w_bypass_hit;
    logic [DATA_W-1:0] w_stored;

    assign w_is_zero = (raddr == ADDR_W'(c_REG_ZERO));
    assign w_stored  = regs[raddr];

`ifdef REG_FILE_WRITE_BYPASS_EN
    // waddr!=0 is implied because the $0 check below wins first.
    assign w_bypass_hit = we && (waddr == raddr);
`else
    logic w_unused_bypass;
    assign w_unused_bypass = &{1'b0, we, waddr, wdata};
    assign w_bypass_hit    = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        if (rd_en && !w_is_zero) begin
`ifdef REG_FILE_WRITE_BYPASS_EN
            if (w_bypass_hit) begin
                rdata = wdata;
            end else begin
                rdata = w_stored;
            end
`else
            rdata = w_bypass_hit ? '0 : w_stored;
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// Module      : reg_file
// Description : MIPS 32-entry GPR file, two combinational read ports, one
//               write-back port and a committed-write counter.
//               Optional write-first forwarding: REG_FILE_WRITE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W,
    parameter int CNT_W  = c_CNT_W
)(
    input  wire logic clk,
    input  wire logic rst_n,
    reg_file_if.slave bus
);

    localparam int c_NREG = 2**ADDR_W;

    logic              w_commit;
    logic [DATA_W-1:0] w_regs [c_NREG];
    logic [CNT_W-1:0]  r_wr_cnt;

    // we is tested first so X on waddr/wdata with we=0 cannot commit.
    assign w_commit = bus.we && (bus.waddr != ADDR_W'(c_REG_ZERO));

    // $0 is not storage: it is a constant zero feeding the read muxes.
    assign w_regs[0] = '0;

    for (genvar i = 1; i < c_NREG; i++) begin : g_regs
        logic [DATA_W-1:0] r_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (w_commit && (bus.waddr == ADDR_W'(i))) begin
                r_q <= bus.wdata;
            end
        end

        assign w_regs[i] = r_q;
    end

    // Wraps modulo 2**CNT_W by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt <= '0;
        end else if (w_commit) begin
            r_wr_cnt <= r_wr_cnt + CNT_W'(1);
        end
    end

    assign bus.wr_cnt = r_wr_cnt;

    reg_file_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd1 (
        .rd_en (rst_n),
        .raddr (bus.raddr1),
        .regs  (w_regs),
        .we    (bus.we),
        .waddr (bus.waddr),
        .wdata (bus.wdata),
        .rdata (bus.rdata1)
    );

    reg_file_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd2 (
        .rd_en (rst_n),
        .raddr (bus.raddr2),
        .regs  (w_regs),
        .we    (bus.we),
        .waddr (bus.waddr),
        .wdata (bus.wdata),
        .rdata (bus.rdata2)
    );

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// Module      : tb_reg_file
// Description : Self-checking bench for reg_file against an array-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;
    localparam int NREG   = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    reg_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_regs [NREG];
    int unsigned m_writes;

    function automatic logic [31:0] exp_rd(input logic [4:0] ra, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (rst_n !== 1'b1 || ra == 5'd0) return 32'h0;
`ifdef REG_FILE_WRITE_BYPASS_EN
        if (we === 1'b1 && wa == ra) return wd;
`endif
        return m_regs[ra];
    endfunction

    function automatic logic [3:0] exp_cnt();
        return 4'(m_writes % 16);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) m_regs[i] = 32'h0;
        m_writes = 0;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        bus.we = we; bus.waddr = wa; bus.wdata = wd; bus.raddr1 = ra1; bus.raddr2 = ra2;
    endtask

    // Advance one edge and apply the architectural write rule to the model.
    task automatic commit();
        @(posedge clk);
        if (rst_n === 1'b1 && bus.we === 1'b1 && bus.waddr != 5'd0) begin
            m_regs[bus.waddr] = bus.wdata;
            m_writes++;
        end
        #1;
    endtask

    task automatic test_reset();
        model_clear();
        rst_n = 1'b0;
        drive(1'b1, 5'd3, $urandom, 5'd3, 5'd0);
        #1;
        n_cmp++; if (bus.rdata1 !== 32'h0) begin n_err++; $display("FAIL rst_rd1: got %h expected %h", bus.rdata1, 32'h0); end
        n_cmp++; if (bus.wr_cnt !== 4'h0) begin n_err++; $display("FAIL rst_cnt: got %h expected %h", bus.wr_cnt, 4'h0); end
        commit();
        n_cmp++; if (bus.rdata1 !== 32'h0) begin n_err++; $display("FAIL rst_nocommit: got %h expected %h", bus.rdata1, 32'h0); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        #1;
        n_cmp++; if (bus.rdata2 !== 32'h0) begin n_err++; $display("FAIL rst_release: got %h expected %h", bus.rdata2, 32'h0); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        commit();
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        #1;
        n_cmp++; if (bus.rdata1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_rd: got %h expected %h", bus.rdata1, 32'hDEADBEEF); end
        n_cmp++; if (bus.wr_cnt !== exp_cnt()) begin n_err++; $display("FAIL wr_cnt: got %h expected %h", bus.wr_cnt, exp_cnt()); end
    endtask

    task automatic test_zero_write();
        logic [3:0] cnt0;
        cnt0 = exp_cnt();
        @(negedge clk);
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        #1;
        n_cmp++; if (bus.rdata2 !== 32'h0) begin n_err++; $display("FAIL zero_pre: got %h expected %h", bus.rdata2, 32'h0); end
        commit();
        n_cmp++; if (bus.rdata2 !== 32'h0) begin n_err++; $display("FAIL zero_post: got %h expected %h", bus.rdata2, 32'h0); end
        n_cmp++; if (bus.wr_cnt !== cnt0) begin n_err++; $display("FAIL zero_cnt: got %h expected %h", bus.wr_cnt, cnt0); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] pre;
`ifdef REG_FILE_WRITE_BYPASS_EN
        pre = 32'h2;
`else
        pre = 32'h1;
`endif
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h1, 5'd0, 5'd0);
        commit();
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h2, 5'd7, 5'd7);
        #1;
        n_cmp++; if (bus.rdata1 !== pre) begin n_err++; $display("FAIL same_pre1: got %h expected %h", bus.rdata1, pre); end
        n_cmp++; if (bus.rdata2 !== pre) begin n_err++; $display("FAIL same_pre2: got %h expected %h", bus.rdata2, pre); end
        commit();
        @(negedge clk);
        bus.we = 1'b0;
        #1;
        n_cmp++; if (bus.rdata1 !== 32'h2) begin n_err++; $display("FAIL same_post1: got %h expected %h", bus.rdata1, 32'h2); end
        n_cmp++; if (bus.rdata2 !== 32'h2) begin n_err++; $display("FAIL same_post2: got %h expected %h", bus.rdata2, 32'h2); end
    endtask

    task automatic test_sweep();
        logic [31:0] e1, e2;
        for (int i = 1; i < NREG; i++) begin
            @(negedge clk);
            drive(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'($urandom), 5'($urandom));
            commit();
        end
        @(negedge clk);
        for (int i = 0; i < NREG; i++) begin
            drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            #1;
            e1 = 32'(i) * 32'h01010101;
            e2 = 32'(31 - i) * 32'h01010101;
            n_cmp++; if (bus.rdata1 !== e1) begin n_err++; $display("FAIL sweep_rd1[%0d]: got %h expected %h", i, bus.rdata1, e1); end
            n_cmp++; if (bus.rdata2 !== e2) begin n_err++; $display("FAIL sweep_rd2[%0d]: got %h expected %h", i, bus.rdata2, e2); end
        end
        n_cmp++; if (bus.wr_cnt !== exp_cnt()) begin n_err++; $display("FAIL sweep_cnt: got %h expected %h", bus.wr_cnt, exp_cnt()); end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            drive(1'($urandom), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
            if ($urandom_range(3) == 0) bus.raddr1 = bus.waddr;
            if (bus.we === 1'b0 && $urandom_range(3) == 0) begin
                bus.waddr = 'x;
                bus.wdata = 'x;
            end
            #1;
            e1 = exp_rd(bus.raddr1, bus.we, bus.waddr, bus.wdata);
            e2 = exp_rd(bus.raddr2, bus.we, bus.waddr, bus.wdata);
            n_cmp++; if (bus.rdata1 !== e1) begin n_err++; $display("FAIL rnd_rd1[%0d]: got %h expected %h", n, bus.rdata1, e1); end
            n_cmp++; if (bus.rdata2 !== e2) begin n_err++; $display("FAIL rnd_rd2[%0d]: got %h expected %h", n, bus.rdata2, e2); end
            commit();
            n_cmp++; if (bus.wr_cnt !== exp_cnt()) begin n_err++; $display("FAIL rnd_cnt[%0d]: got %h expected %h", n, bus.wr_cnt, exp_cnt()); end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_clear();
        for (int i = 0; i < NREG; i++) begin
            drive(1'b1, 5'(i), $urandom, 5'(i), 5'(31 - i));
            #1;
            n_cmp++; if (bus.rdata1 !== 32'h0) begin n_err++; $display("FAIL arst_rd1[%0d]: got %h expected %h", i, bus.rdata1, 32'h0); end
            n_cmp++; if (bus.rdata2 !== 32'h0) begin n_err++; $display("FAIL arst_rd2[%0d]: got %h expected %h", i, bus.rdata2, 32'h0); end
        end
        n_cmp++; if (bus.wr_cnt !== 4'h0) begin n_err++; $display("FAIL arst_cnt: got %h expected %h", bus.wr_cnt, 4'h0); end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            drive(1'b1, 5'd1, 32'(n), 5'd1, 5'd0);
            commit();
            if (n == 16) begin
                n_cmp++; if (bus.wr_cnt !== 4'h0) begin n_err++; $display("FAIL wrap16: got %h expected %h", bus.wr_cnt, 4'h0); end
            end
        end
        n_cmp++; if (bus.wr_cnt !== 4'h1) begin n_err++; $display("FAIL wrap17: got %h expected %h", bus.wr_cnt, 4'h1); end
        n_cmp++; if (bus.wr_cnt !== exp_cnt()) begin n_err++; $display("FAIL wrap_model: got %h expected %h", bus.wr_cnt, exp_cnt()); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_write();
        test_same_cycle();
        test_sweep();
        test_random();
        test_async_reset();
        test_wrap();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
